// File: rtl/rat_int_sequencer_pkg.sv
// Shared types and constants for the RAT fetch/execute/interrupt sequencer.
// Holds the state encoding, default parameter values and the vector helper.
// No logic; imported by the sequencer, its interrupt front end and interface.
package rat_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam int         DEF_NUM_IRQ  = 4;
    localparam int         DEF_VEC_W    = 10;
    localparam logic [9:0] DEF_VEC_BASE = 10'h3FF;

    // Index width for NUM_IRQ sources; a single source still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry vector of source k. The caller truncates to VEC_W, which makes
    // the subtraction wrap modulo 2^VEC_W.
    function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [31:0] k);
        return base - k;
    endfunction

endpackage

// File: rtl/rat_int_sequencer_if.sv
// Control-path bundle between the RAT control unit and the sequencer.
// Pure wiring, zero latency; no backpressure (strobes are single-cycle pulses).
// master = decode/control unit side, slave = sequencer side.
interface rat_int_sequencer_if #(
    parameter int NUM_IRQ = rat_seq_pkg::DEF_NUM_IRQ,
    parameter int VEC_W   = rat_seq_pkg::DEF_VEC_W
);
    localparam int ID_W = rat_seq_pkg::id_width(NUM_IRQ);

    // Inputs to the sequencer
    logic [NUM_IRQ-1:0] IRQ;
    logic               IRQ_MASK_WR;
    logic [NUM_IRQ-1:0] IRQ_MASK_DATA;
    logic               MULTI;
    logic               I_SET;
    logic               I_CLR;
    logic               RETI;

    // Outputs from the sequencer
    logic [2:0]         STATE;
    logic               RST;
    logic               PC_INC;
    logic               INT_ACK;
    logic [ID_W-1:0]    INT_ID;
    logic [VEC_W-1:0]   INT_VEC;
    logic               I_FLAG;
    logic [NUM_IRQ-1:0] IRQ_PEND;

    modport master (
        output IRQ, IRQ_MASK_WR, IRQ_MASK_DATA, MULTI, I_SET, I_CLR, RETI,
        input  STATE, RST, PC_INC, INT_ACK, INT_ID, INT_VEC, I_FLAG, IRQ_PEND
    );

    modport slave (
        input  IRQ, IRQ_MASK_WR, IRQ_MASK_DATA, MULTI, I_SET, I_CLR, RETI,
        output STATE, RST, PC_INC, INT_ACK, INT_ID, INT_VEC, I_FLAG, IRQ_PEND
    );

endinterface

// File: rtl/rat_int_sequencer_prio.sv
// rat_irq_prio: IRQ edge detect, pending/mask registers, priority pick.
// Latency: IRQ rising edge -> pending 1 cycle; pick is combinational from regs.
// No backpressure: pending bits hold until acknowledged, masked bits wait.
// Ports: clk/rst_n; irq raw lines; mask_wr/mask_dat mask load; ack_vld/ack_idx
// clear the serviced source; pend, any_vld, win_idx out.
// Optional RAT_INT_NEST_EN adds an in-service register and the reti_vld port.
module rat_irq_prio
    import rat_seq_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_dat,
    input  logic               ack_vld,
    input  logic [ID_W-1:0]    ack_idx,
`ifdef RAT_INT_NEST_EN
    input  logic               reti_vld,
`endif
    output logic [NUM_IRQ-1:0] pend,
    output logic               any_vld,
    output logic [ID_W-1:0]    win_idx
);

    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] ack_onehot;
    logic [NUM_IRQ-1:0] elig;

`ifdef RAT_INT_NEST_EN
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] isr_low;
    logic [NUM_IRQ-1:0] below_isr;
`endif

    always_comb begin
        ack_onehot = ack_vld ? (NUM_IRQ'(1) << ack_idx) : '0;
        irq_prev_d = irq;
        // A new edge on the same bit being acknowledged must not be lost.
        pend_d     = (pend_q & ~ack_onehot) | (irq & ~irq_prev_q);
        mask_d     = mask_wr ? mask_dat : mask_q;
    end

`ifdef RAT_INT_NEST_EN
    always_comb begin
        // Lowest set in-service bit, and the sources strictly more urgent.
        isr_low   = isr_q & (~isr_q + NUM_IRQ'(1));
        below_isr = (isr_q == '0) ? '1 : (isr_low - NUM_IRQ'(1));
        isr_d     = isr_q;
        if (reti_vld) isr_d = isr_d & ~isr_low;
        isr_d     = isr_d | ack_onehot;
        elig      = pend_q & mask_q & below_isr;
    end
`else
    always_comb begin
        elig = pend_q & mask_q;
    end
`endif

    // Lowest index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_idx = ID_W'(i);
        end
        any_vld = |elig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
            mask_q     <= '1;
        end else begin
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
        end
    end

`ifdef RAT_INT_NEST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) isr_q <= '0;
        else        isr_q <= isr_d;
    end
`endif

    assign pend = pend_q;

endmodule

// File: rtl/rat_int_sequencer.sv
// RAT fetch/execute/interrupt sequencer with vectored, prioritised entry.
// Latency: 2 cycles per instruction, 3 with MULTI, +1 for interrupt entry.
// No backpressure: all strobes are Moore outputs of the registered state.
// Ports: CLK, RESET_N (async active-low); bus (slave) carries IRQ, mask
// write, decode controls MULTI/I_SET/I_CLR/RETI in, and STATE, RST, PC_INC,
// INT_ACK, INT_ID, INT_VEC, I_FLAG, IRQ_PEND out.
// Build option RAT_INT_NEST_EN: nested interrupts via an in-service register.
module rat_int_sequencer
    import rat_seq_pkg::*;
#(
    parameter int               NUM_IRQ  = DEF_NUM_IRQ,
    parameter int               VEC_W    = DEF_VEC_W,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(DEF_VEC_BASE)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    rat_int_sequencer_if.slave  bus
);

    localparam int ID_W = id_width(NUM_IRQ);

    state_t          state_q, state_d;
    logic            i_flag_q, i_flag_d;
    logic [ID_W-1:0] int_id_q, int_id_d;

    logic            honour;
    logic            eoi;
    logic            take;
    logic            any_vld;
    logic [ID_W-1:0] win_idx;
    logic            int_ack;

    rat_irq_prio #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .irq      (bus.IRQ),
        .mask_wr  (bus.IRQ_MASK_WR),
        .mask_dat (bus.IRQ_MASK_DATA),
        .ack_vld  (int_ack),
        .ack_idx  (int_id_q),
`ifdef RAT_INT_NEST_EN
        .reti_vld (honour & bus.RETI),
`endif
        .pend     (bus.IRQ_PEND),
        .any_vld  (any_vld),
        .win_idx  (win_idx)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
            int_id_q <= int_id_d;
        end
    end

    // Next-state logic
    always_comb begin
        honour = (state_q == ST_EXEC) || (state_q == ST_EXEC2);
        eoi    = ((state_q == ST_EXEC) && !bus.MULTI) || (state_q == ST_EXEC2);
        // Registered I_FLAG: an I_SET only opens the window after the next
        // instruction, while an I_CLR in the last cycle closes it at once.
        take   = eoi && i_flag_q && !bus.I_CLR && any_vld;

        state_d = state_q;
        unique case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = bus.MULTI ? ST_EXEC2 : (take ? ST_INTR : ST_FETCH);
            ST_EXEC2: state_d = take ? ST_INTR : ST_FETCH;
            ST_INTR:  state_d = ST_FETCH;
            default:  state_d = ST_INIT;
        endcase

        int_id_d = take ? win_idx : int_id_q;

        i_flag_d = i_flag_q;
        if (honour && (bus.I_SET || bus.RETI)) i_flag_d = 1'b1;
        if (honour && bus.I_CLR)               i_flag_d = 1'b0;
`ifndef RAT_INT_NEST_EN
        if (state_q == ST_INTR)                i_flag_d = 1'b0;
`endif
    end

    // Output logic
    always_comb begin
        int_ack     = (state_q == ST_INTR);
        bus.STATE   = state_q;
        bus.RST     = (state_q == ST_INIT);
        bus.PC_INC  = (state_q == ST_FETCH);
        bus.INT_ACK = int_ack;
        bus.INT_ID  = int_id_q;
        bus.INT_VEC = VEC_W'(vec_of(32'(VEC_BASE), 32'(int_id_q)));
        bus.I_FLAG  = i_flag_q;
    end

endmodule

// File: tb/tb_rat_int_sequencer.sv
module tb_rat_int_sequencer;
    import rat_seq_pkg::*;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    rat_int_sequencer_if #(.NUM_IRQ(4), .VEC_W(10)) bus ();

    rat_int_sequencer #(
        .NUM_IRQ  (4),
        .VEC_W    (10),
        .VEC_BASE (10'h3FF)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    // Control bits: {MULTI, I_SET, I_CLR, RETI, IRQ_MASK_WR}
    localparam logic [4:0] C0 = 5'b00000;
    localparam logic [4:0] CM = 5'b10000;
    localparam logic [4:0] CS = 5'b01000;
    localparam logic [4:0] CC = 5'b00100;
    localparam logic [4:0] CR = 5'b00010;
    localparam logic [4:0] CW = 5'b00001;

    typedef struct {
        logic [3:0] irq;
        logic [4:0] ctl;
        logic [3:0] mdat;
        state_t     st;
        logic       iflag;
        logic [3:0] pend;
        logic [1:0] id;
    } vec_t;

    vec_t tv[$];
    int n_chk  = 0;
    int n_pass = 0;
    logic [9:0] vtab [4] = '{10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic add(input logic [3:0] irq, input logic [4:0] ctl, input logic [3:0] mdat,
                       input state_t st, input logic iflag, input logic [3:0] pend,
                       input logic [1:0] id);
        vec_t v;
        v.irq = irq; v.ctl = ctl; v.mdat = mdat;
        v.st = st; v.iflag = iflag; v.pend = pend; v.id = id;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [3:0] irq, input logic [4:0] ctl, input logic [3:0] mdat);
        bus.IRQ           = irq;
        bus.MULTI         = ctl[4];
        bus.I_SET         = ctl[3];
        bus.I_CLR         = ctl[2];
        bus.RETI          = ctl[1];
        bus.IRQ_MASK_WR   = ctl[0];
        bus.IRQ_MASK_DATA = mdat;
    endtask

    task automatic cyc(input logic [3:0] irq, input logic [4:0] ctl);
        drive(irq, ctl, 4'h0);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_core(input string tag, input state_t st, input logic iflag,
                            input logic [3:0] pend);
        chk({tag, " state"},   32'(bus.STATE),   32'(st));
        chk({tag, " rst"},     32'(bus.RST),     32'(st == ST_INIT));
        chk({tag, " pc_inc"},  32'(bus.PC_INC),  32'(st == ST_FETCH));
        chk({tag, " int_ack"}, 32'(bus.INT_ACK), 32'(st == ST_INTR));
        chk({tag, " i_flag"},  32'(bus.I_FLAG),  32'(iflag));
        chk({tag, " pend"},    32'(bus.IRQ_PEND), 32'(pend));
    endtask

    initial begin
        drive(4'h0, C0, 4'h0);

        // ---- reset values while held in reset
        #12;
        chk_core("reset", ST_INIT, 1'b0, 4'h0);
        chk("reset int_vec", 32'(bus.INT_VEC), 32'h3FF);
        chk("reset int_id",  32'(bus.INT_ID),  32'h0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        chk("init after release", 32'(bus.STATE), 32'(ST_INIT));

        // ---- cycle table: row applies inputs, then one edge, then compare
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);   // 0
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h0, CS, 4'h0, ST_FETCH, 1, 4'h0, 0);   // I_SET
        add(4'h4, C0, 4'h0, ST_EXEC,  1, 4'h4, 0);   // IRQ[2] rises
        add(4'h4, C0, 4'h0, ST_INTR,  1, 4'h4, 2);   // entry after EXEC
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);
        add(4'hA, C0, 4'h0, ST_EXEC,  0, 4'hA, 0);   // IRQ[1],IRQ[3] together
        add(4'h0, CR, 4'h0, ST_FETCH, 1, 4'hA, 0);   // RETI
        add(4'h0, C0, 4'h0, ST_EXEC,  1, 4'hA, 0);   // 10
        add(4'h0, C0, 4'h0, ST_INTR,  1, 4'hA, 1);   // source 1 first
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h8, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h8, 0);
        add(4'h0, CR, 4'h0, ST_FETCH, 1, 4'h8, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  1, 4'h8, 0);
        add(4'h0, C0, 4'h0, ST_INTR,  1, 4'h8, 3);   // then source 3
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h1, CS, 4'h0, ST_FETCH, 1, 4'h1, 0);
        add(4'h1, C0, 4'h0, ST_EXEC,  1, 4'h1, 0);   // 20
        add(4'h1, CM, 4'h0, ST_EXEC2, 1, 4'h1, 0);   // MULTI: no entry yet
        add(4'h1, C0, 4'h0, ST_INTR,  1, 4'h1, 0);
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h0, CS | CC, 4'h0, ST_FETCH, 0, 4'h0, 0);  // I_CLR beats I_SET
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h0, CS | CW, 4'h0, ST_FETCH, 1, 4'h0, 0);  // mask = 0
        add(4'h4, C0, 4'h0, ST_EXEC,  1, 4'h4, 0);
        add(4'h4, C0, 4'h0, ST_FETCH, 1, 4'h4, 0);   // masked: stays pending
        add(4'h4, C0, 4'h0, ST_EXEC,  1, 4'h4, 0);   // 30
        add(4'h4, CW, 4'hF, ST_FETCH, 1, 4'h4, 0);   // mask write not yet seen
        add(4'h4, C0, 4'h0, ST_EXEC,  1, 4'h4, 0);
        add(4'h4, C0, 4'h0, ST_INTR,  1, 4'h4, 2);
        add(4'h0, C0, 4'h0, ST_FETCH, 0, 4'h0, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h0, 0);
        add(4'h2, CS, 4'h0, ST_FETCH, 1, 4'h2, 0);
        add(4'h0, C0, 4'h0, ST_EXEC,  1, 4'h2, 0);
        add(4'h0, CC, 4'h0, ST_FETCH, 0, 4'h2, 0);   // I_CLR blocks take
        add(4'h0, C0, 4'h0, ST_EXEC,  0, 4'h2, 0);
        add(4'h0, CS, 4'h0, ST_FETCH, 1, 4'h2, 0);   // 40
        add(4'h0, C0, 4'h0, ST_EXEC,  1, 4'h2, 0);
        add(4'h0, C0, 4'h0, ST_INTR,  1, 4'h2, 1);
        add(4'h2, C0, 4'h0, ST_FETCH, 0, 4'h2, 0);   // set beats ack clear
        add(4'h2, C0, 4'h0, ST_EXEC,  0, 4'h2, 0);
        add(4'h2, CS, 4'h0, ST_FETCH, 1, 4'h2, 0);
        add(4'h2, C0, 4'h0, ST_EXEC,  1, 4'h2, 0);
        add(4'hA, C0, 4'h0, ST_INTR,  1, 4'hA, 1);   // 47: ends in INTR

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].irq, tv[i].ctl, tv[i].mdat);
            @(posedge CLK); #1;
            chk_core($sformatf("r%0d", i), tv[i].st, tv[i].iflag, tv[i].pend);
            if (tv[i].st == ST_INTR) begin
                chk($sformatf("r%0d int_id", i),  32'(bus.INT_ID),  32'(tv[i].id));
                chk($sformatf("r%0d int_vec", i), 32'(bus.INT_VEC), 32'(vtab[tv[i].id]));
            end
        end

        // ---- asynchronous reset in the middle of INTR
        #2;
        RESET_N = 1'b0;
        #1;
        chk_core("async rst", ST_INIT, 1'b0, 4'h0);
        chk("async rst int_vec", 32'(bus.INT_VEC), 32'h3FF);
        chk("async rst int_id",  32'(bus.INT_ID),  32'h0);
        @(posedge CLK); #1;
        chk("held rst state", 32'(bus.STATE), 32'(ST_INIT));
        RESET_N = 1'b1;
        // IRQ lines still high: the cleared edge register sees fresh edges.
        @(posedge CLK); #1;
        chk_core("post rst", ST_FETCH, 1'b0, 4'hA);

`ifdef RAT_INT_NEST_EN
        // ---- nesting: handler for source 2 preempted by 0, not by 3
        RESET_N = 1'b0;
        cyc(4'h0, C0);
        RESET_N = 1'b1;
        cyc(4'h0, C0);              // FETCH
        cyc(4'h0, C0);              // EXEC
        cyc(4'h0, CS);              // FETCH, I_FLAG=1
        cyc(4'h4, C0);              // EXEC, pend[2]
        cyc(4'h4, C0);              // INTR
        chk("nest entry2 state", 32'(bus.STATE), 32'(ST_INTR));
        chk("nest entry2 id", 32'(bus.INT_ID), 32'h2);
        cyc(4'h0, C0);              // FETCH
        chk("nest iflag kept", 32'(bus.I_FLAG), 32'h1);
        cyc(4'h8, C0);              // EXEC, pend[3]
        cyc(4'h8, C0);              // FETCH: 3 not eligible
        chk("nest irq3 blocked", 32'(bus.STATE), 32'(ST_FETCH));
        cyc(4'h9, C0);              // EXEC, pend[0]
        cyc(4'h9, C0);              // INTR for 0
        chk("nest preempt state", 32'(bus.STATE), 32'(ST_INTR));
        chk("nest preempt vec", 32'(bus.INT_VEC), 32'h3FF);
        cyc(4'h0, C0);              // FETCH
        cyc(4'h0, C0);              // EXEC
        cyc(4'h0, CR);              // FETCH, leave handler 0
        cyc(4'h0, C0);              // EXEC
        cyc(4'h0, C0);              // FETCH: still inside handler 2
        chk("nest still blocked", 32'(bus.STATE), 32'(ST_FETCH));
        chk("nest pend3", 32'(bus.IRQ_PEND), 32'h8);
        cyc(4'h0, C0);              // EXEC
        cyc(4'h0, CR);              // FETCH, leave handler 2
        cyc(4'h0, C0);              // EXEC
        cyc(4'h0, C0);              // INTR for 3
        chk("nest entry3 state", 32'(bus.STATE), 32'(ST_INTR));
        chk("nest entry3 id", 32'(bus.INT_ID), 32'h3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rat_int_sequencer.md
# rat_int_sequencer

Parametrised fetch/execute/interrupt sequencer for the RAT CPU control path. It supersedes the fixed three-state INIT/FETCH/EXEC sequencing with a multi-cycle execute state and an NUM_IRQ-channel, maskable, prioritised interrupt front end. It also generates vectored interrupt entry. Opcode decode stays in the control unit, which feeds this block MULTI, I_SET, I_CLR and RETI during EXEC.

## Interface
- NUM_IRQ, 4: interrupt source count (1..16).
- VEC_W, 10: PC/vector width.
- VEC_BASE, 10'h3FF: vector of source 0; source k vectors to (VEC_BASE - k) mod 2^VEC_W.

- CLK  in  1  rising-edge clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- IRQ  in  NUM_IRQ  raw interrupt lines, synchronous to CLK, rising-edge detected.
- IRQ_MASK_WR  in  1  load mask register.
- IRQ_MASK_DATA  in  NUM_IRQ  mask value (1 = enabled).
- MULTI  in  1  current opcode needs a second execute cycle; sampled in EXEC.
- I_SET, I_CLR, RETI  in  1  global-enable controls from decode; honoured in EXEC/EXEC2 only.
- STATE  out  3  current state (package enum).
- RST  out  1  datapath reset strobe.
- PC_INC  out  1  fetch strobe.
- INT_ACK  out  1  interrupt entry strobe; also drives PC_LD, SP_DECR, SCR_WE, FLG_SHAD_LD upstream.
- INT_ID  out  $clog2(NUM_IRQ) (min 1)  serviced source index.
- INT_VEC  out  VEC_W  entry vector.
- I_FLAG  out  1  global interrupt enable.
- IRQ_PEND  out  NUM_IRQ  pending register.

## Operation
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_EXEC2, ST_INTR.
- INIT: RST=1; next FETCH. FETCH: PC_INC=1; next EXEC.
- EXEC: MULTI=1 -> EXEC2, else end of instruction. EXEC2 is always end of instruction.
- End of instruction: take = I_FLAG & |(IRQ_PEND & mask). If take -> INTR, else FETCH.
- take uses the registered I_FLAG, so I_SET in an instruction enables interrupts only after the following instruction. I_CLR in the final cycle blocks take in that cycle.
- Priority: lowest enabled pending index wins. It is latched into INT_ID on the EXEC->INTR transition.
- INTR lasts one cycle: INT_ACK=1, INT_VEC valid, pending[INT_ID] cleared, I_FLAG cleared; next FETCH.
- I_FLAG: set by I_SET or RETI, cleared by I_CLR or INT_ACK. If I_CLR coincides with I_SET or RETI, I_CLR wins.
- Pending bit k is set on rising edge of IRQ[k] (previous-sample register). If a set and a clear hit the same bit in one cycle, the set wins.
- Masked pending bits stay pending. A mask write takes effect next cycle.
- Vector arithmetic is modulo 2^VEC_W.

## Timing
- Reset values: state INIT, I_FLAG 0, IRQ_PEND 0, mask all-ones, edge register 0, INT_ID 0.
- Reset values of outputs: RST 1, all strobes 0, INT_VEC = VEC_BASE.
- Asserting RESET_N low mid-operation (including INTR) forces reset values immediately. The first cycle after release is INIT.
- All strobes are Moore outputs of the registered state.
- IRQ edge to pending: 1 cycle.
- Worst-case latency from pending to INT_ACK: 3 cycles (FETCH, EXEC, EXEC2) plus 1.
- Instruction throughput: 2 cycles normal, 3 cycles with MULTI; interrupt entry adds 1.

## Configuration
- RAT_INT_NEST_EN defined: adds an in-service register ISR[NUM_IRQ] (reset 0).
  - INT_ACK sets ISR[INT_ID] and leaves I_FLAG unchanged.
  - A source is eligible only if its index is below the lowest set ISR bit.
  - RETI clears the lowest set ISR bit.
  - I_CLR still globally disables.
- Undefined: no ISR; INT_ACK clears I_FLAG; non-nesting.

## Structure
- Package rat_seq_pkg: state enum, default parameter constants, vector function (VEC_BASE - k).
- Sub-module rat_irq_prio: edge detect, pending/mask registers, optional ISR filter, priority encoder. It outputs any-eligible and the winning index.

## Test plan
- Reset release, MULTI=0: RST high 1 cycle, then PC_INC every 2nd cycle, STATE alternating FETCH/EXEC.
- I_FLAG=1, IRQ[2] pulse: INTR follows the current EXEC, with INT_ACK=1, INT_VEC=0x3FD, INT_ID=2; IRQ_PEND[2] and I_FLAG return to 0.
- IRQ[1] and IRQ[3] rise in the same cycle: vector 0x3FE serviced first. After RETI and one instruction, vector 0x3FC is serviced.
- MULTI=1 with pending IRQ: sequence is EXEC, EXEC2, INTR; the interrupt is never taken between EXEC and EXEC2.
- I_SET and I_CLR in the same EXEC: I_FLAG=0. Mask=0 with pending bit: no entry until mask is written to 1.
- RESET_N low during INTR: RST=1 and IRQ_PEND=0 immediately, STATE=INIT. With RAT_INT_NEST_EN, IRQ[0] preempts a handler for source 2 but IRQ[3] does not.
